// File: rtl/sfu_pkg.sv
// Shared op encodings, FSM state enum and counter widths for the convolution sequencer.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package sfu_pkg;

    localparam int CNT_W = 8;   // row/col/kernel counters
    localparam int OIJ_W = 16;  // output pixel index

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_SET  = 2'b01,
        OP_ACC  = 2'b10,
        OP_RELU = 2'b11
    } sfu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_ACC,
        ST_RELU,
        ST_RELU_WAIT,
        ST_WRITEBACK,
        ST_DONE
    } sfu_state_e;

    // SFU op issued for a given sequencer state; RELU slot degrades to NOP when disabled.
    function automatic sfu_op_e state_op(input sfu_state_e st, input logic relu_en);
        sfu_op_e op;
        op = OP_NOP;
        case (st)
            ST_SET:  op = OP_SET;
            ST_ACC:  op = OP_ACC;
            ST_RELU: op = relu_en ? OP_RELU : OP_NOP;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sfu_conv_sequencer_if.sv
// Control/status bundle between a host and the convolution sequencer.
// Latency: n/a (wiring only).
// Backpressure: stall is the only throttle; the host holds it to freeze sequencing.
interface sfu_conv_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int NUM_OC = 8
);
    logic                  start;
    logic                  stall;
    logic                  cfg_relu_en;
    logic [ADDR_W-1:0]     psum_mem_addr;
    logic                  psum_mem_rd_enable;
    logic                  psum_mem_wr_enable;
    logic                  busy;
    logic                  done;
    logic [2*NUM_OC-1:0]   sfu_op_array;

    modport master (
        output start, stall, cfg_relu_en,
        input  psum_mem_addr, psum_mem_rd_enable, psum_mem_wr_enable, busy, done, sfu_op_array
    );

    modport slave (
        input  start, stall, cfg_relu_en,
        output psum_mem_addr, psum_mem_rd_enable, psum_mem_wr_enable, busy, done, sfu_op_array
    );
endinterface

// File: rtl/sfu_addr_gen.sv
// PSUM read/write address generation from output pixel and kernel tap coordinates.
// Latency: combinational, 0 cycles.
// Backpressure: none; caller registers the result and holds counters when stalled.
module sfu_addr_gen
    import sfu_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int IN_W    = 6,
    parameter int KER_W   = 3,
    parameter int STRIDE  = 1,
    parameter int WB_BASE = 0
) (
    input  logic [CNT_W-1:0]  i_orow,
    input  logic [CNT_W-1:0]  i_ocol,
    input  logic [CNT_W-1:0]  i_kr,
    input  logic [CNT_W-1:0]  i_kc,
    input  logic [OIJ_W-1:0]  i_oij,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W-1:0] o_wr_addr
);
    localparam int NUM_NIJ = IN_W * IN_W;

    // Each kernel tap k owns a NUM_NIJ-sized plane; inside it, index the input pixel under the tap.
    assign o_rd_addr = ADDR_W'((32'(i_kr) * KER_W + 32'(i_kc)) * NUM_NIJ
                             + (32'(i_orow) * STRIDE + 32'(i_kr)) * IN_W
                             + 32'(i_ocol) * STRIDE + 32'(i_kc));

    // Results land densely from WB_BASE in row-major output order.
    assign o_wr_addr = ADDR_W'(WB_BASE + 32'(i_oij));
endmodule

// File: rtl/sfu_conv_sequencer.sv
// Sequences SET/ACC/RELU ops and PSUM reads/writeback per output pixel; optional perf counters (SFU_SEQ_PERF_CNT_EN).
// Latency: addr/enables 1 cycle after state, op lanes 2 cycles after state; NUM_KIJ+3 cycles per pixel.
// Backpressure: stall freezes state/counters/address, drops enables and injects NOP ops.
module sfu_conv_sequencer
    import sfu_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int NUM_OC  = 8,
    parameter int IN_W    = 6,
    parameter int KER_W   = 3,
    parameter int STRIDE  = 1,
    parameter int WB_BASE = 0
) (
    input  logic clk,
    input  logic reset_n,
`ifdef SFU_SEQ_PERF_CNT_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_stalls,
`endif
    sfu_conv_sequencer_if.slave bus
);
    localparam int NUM_KIJ = KER_W * KER_W;
    localparam int OUT_W   = (IN_W - KER_W) / STRIDE + 1;
    localparam int NUM_OIJ = OUT_W * OUT_W;

    localparam logic [CNT_W-1:0] KER_LAST = CNT_W'(KER_W - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_W - 1);
    localparam logic [OIJ_W-1:0] OIJ_LAST = OIJ_W'(NUM_OIJ - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [OIJ_W-1:0] OIJ_ONE  = OIJ_W'(1);

    sfu_state_e        r_state;
    logic [CNT_W-1:0]  r_orow, r_ocol, r_kr, r_kc;
    logic [OIJ_W-1:0]  r_oij;
    logic              r_relu_en;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic              r_wr_en;
    sfu_op_e           r_op_s1;
    sfu_op_e           r_op_s2;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    sfu_addr_gen #(
        .ADDR_W (ADDR_W),
        .IN_W   (IN_W),
        .KER_W  (KER_W),
        .STRIDE (STRIDE),
        .WB_BASE(WB_BASE)
    ) u_addr_gen (
        .i_orow   (r_orow),
        .i_ocol   (r_ocol),
        .i_kr     (r_kr),
        .i_kc     (r_kc),
        .i_oij    (r_oij),
        .o_rd_addr(w_rd_addr),
        .o_wr_addr(w_wr_addr)
    );

    // Control FSM: walks kernel taps per pixel, then pixels row-major; DONE always returns to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_orow    <= '0;
            r_ocol    <= '0;
            r_kr      <= '0;
            r_kc      <= '0;
            r_oij     <= '0;
            r_relu_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state   <= ST_SET;
                        r_busy    <= 1'b1;
                        r_relu_en <= bus.cfg_relu_en;
                        r_orow    <= '0;
                        r_ocol    <= '0;
                        r_kr      <= '0;
                        r_kc      <= '0;
                        r_oij     <= '0;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: begin
                    if (!bus.stall) begin
                        case (r_state)
                            ST_SET: begin
                                if (NUM_KIJ > 1) begin
                                    r_state <= ST_ACC;
                                    r_kc    <= CNT_ONE;
                                end else begin
                                    r_state <= ST_RELU;
                                end
                            end
                            ST_ACC: begin
                                if (r_kr == KER_LAST && r_kc == KER_LAST) begin
                                    r_state <= ST_RELU;
                                    r_kr    <= '0;
                                    r_kc    <= '0;
                                end else if (r_kc == KER_LAST) begin
                                    r_kc <= '0;
                                    r_kr <= r_kr + CNT_ONE;
                                end else begin
                                    r_kc <= r_kc + CNT_ONE;
                                end
                            end
                            ST_RELU:      r_state <= ST_RELU_WAIT;
                            ST_RELU_WAIT: r_state <= ST_WRITEBACK;
                            ST_WRITEBACK: begin
                                if (r_oij == OIJ_LAST) begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_oij   <= '0;
                                    r_orow  <= '0;
                                    r_ocol  <= '0;
                                end else begin
                                    r_state <= ST_SET;
                                    r_oij   <= r_oij + OIJ_ONE;
                                    if (r_ocol == OUT_LAST) begin
                                        r_ocol <= '0;
                                        r_orow <= r_orow + CNT_ONE;
                                    end else begin
                                        r_ocol <= r_ocol + CNT_ONE;
                                    end
                                end
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Memory strobes one cycle behind the state; op lanes two behind so they meet read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_op_s1 <= OP_NOP;
            r_op_s2 <= OP_NOP;
        end else begin
            r_rd_en <= !bus.stall && (r_state == ST_SET || r_state == ST_ACC);
            r_wr_en <= !bus.stall && (r_state == ST_WRITEBACK);
            if (!bus.stall) begin
                if (r_state == ST_SET || r_state == ST_ACC) begin
                    r_addr <= w_rd_addr;
                end else if (r_state == ST_WRITEBACK) begin
                    r_addr <= w_wr_addr;
                end
            end
            r_op_s1 <= bus.stall ? OP_NOP : state_op(r_state, r_relu_en);
            r_op_s2 <= r_op_s1;
        end
    end

    assign bus.psum_mem_addr      = r_addr;
    assign bus.psum_mem_rd_enable = r_rd_en;
    assign bus.psum_mem_wr_enable = r_wr_en;
    assign bus.busy               = r_busy;
    assign bus.done               = r_done;
    assign bus.sfu_op_array       = {NUM_OC{2'(r_op_s2)}};

`ifdef SFU_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    // Busy/stall cycle counters: cleared by an accepted start, frozen once the map completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_busy) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
            if (bus.stall) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`endif
endmodule

// File: doc/sfu_conv_sequencer.md
SFU_CONV_SEQUENCER -- requirements
Module: sfu_conv_sequencer

Interface
REQ-001 Parameter ADDR_W, 11, PSUM memory address width.
REQ-002 Parameter NUM_OC, 8, output channels; each gets one 2-bit op lane.
REQ-003 Parameter IN_W, 6, input feature-map row width (NUM_NIJ = IN_W*IN_W).
REQ-004 Parameter KER_W, 3, kernel row width (NUM_KIJ = KER_W*KER_W); legal range 1..7.
REQ-005 Parameter STRIDE, 1, convolution stride; OUT_W = (IN_W-KER_W)/STRIDE+1, NUM_OIJ = OUT_W*OUT_W.
REQ-006 Parameter WB_BASE, 0, first writeback address.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle request to process a full output map.
REQ-010 stall  in  1  freezes sequencing while high.
REQ-011 cfg_relu_en  in  1  1 = apply RELU, 0 = pass-through (op NOP in RELU slot); sampled with start.
REQ-012 psum_mem_addr  out  ADDR_W  PSUM read/write address.
REQ-013 psum_mem_rd_enable  out  1  read strobe.
REQ-014 psum_mem_wr_enable  out  1  write strobe.
REQ-015 busy  out  1  high from cycle after accepted start until done.
REQ-016 done  out  1  one-cycle pulse after the last writeback.
REQ-017 sfu_op_array  out  2*NUM_OC  op replicated per channel: NOP=00, SET=01, ACC=10, RELU=11.

Function
REQ-018 FSM states IDLE, SET, ACC, RELU, RELU_WAIT, WRITEBACK, DONE.
REQ-019 IDLE->SET when start; start while not IDLE is ignored.
REQ-020 SET->ACC (NUM_KIJ>1) or SET->RELU (NUM_KIJ=1); ACC holds for NUM_KIJ-1 cycles, then RELU; RELU->RELU_WAIT->WRITEBACK.
REQ-021 WRITEBACK->SET if oij_idx < NUM_OIJ-1, else ->DONE; DONE->IDLE unconditionally, done=1 in DONE only.
REQ-022 Read address for output (orow,ocol), kernel (kr,kc): k*NUM_NIJ + (orow*STRIDE+kr)*IN_W + ocol*STRIDE+kc, k=kr*KER_W+kc; computed modulo 2^ADDR_W.
REQ-023 SET reads k=0; ACC reads k=1..NUM_KIJ-1 in row-major order; kc wraps at KER_W-1 with kr increment.
REQ-024 WRITEBACK writes address WB_BASE+oij_idx, oij_idx row-major 0..NUM_OIJ-1.
REQ-025 Address/enables registered: state in cycle t drives psum_mem_addr and enables in cycle t+1; rd_enable only for SET/ACC, wr_enable only for WRITEBACK.
REQ-026 sfu_op_array for state in cycle t appears in cycle t+2 (aligns with 1-cycle memory read data); RELU slot emits 00 when cfg_relu_en latched 0; RELU_WAIT, WRITEBACK, IDLE, DONE emit 00.
REQ-027 Per-pixel cost NUM_KIJ+3 cycles without stall; full map NUM_OIJ*(NUM_KIJ+3)+1 cycles from SET to DONE.
REQ-028 stall high: state, counters, psum_mem_addr held; rd/wr enables 0 next cycle; op pipeline injects 00; resumes exactly where frozen.
REQ-029 stall in IDLE does not block start acceptance.

Reset
REQ-030 reset_n low asynchronously forces IDLE, all counters 0, psum_mem_addr 0, enables 0, busy 0, done 0, sfu_op_array 0, including mid-operation; no writeback completes after reset.

Configuration
REQ-031 Macro SFU_SEQ_PERF_CNT_EN: when defined, adds output perf_cycles (32 bits) counting busy cycles and perf_stalls (32 bits) counting busy&&stall cycles, cleared on accepted start, held after done; when undefined, ports and counters absent, behaviour otherwise identical.

Structure
REQ-032 Shared package sfu_pkg holds op encodings (NOP/SET/ACC/RELU) and FSM state enum.
REQ-033 Sub-module sfu_addr_gen computes read/write addresses from (orow,ocol,kr,kc,oij_idx).

Verification (defaults: IN_W=6, KER_W=3, STRIDE=1, NUM_OC=8, WB_BASE=0)
REQ-034 start, cfg_relu_en=1 -> first pixel reads addresses 0,37,74,114,151,188,228,265,302; writeback addr 0; done 193 cycles after SET entry.
REQ-035 Pixel oij=5 (orow=1,ocol=1) -> first read address 7; writeback address 5.
REQ-036 cfg_relu_en=0 -> lanes show 01, 10x8, 00 in RELU slot; sfu_op_array all-zero 16 bits.
REQ-037 stall high 4 cycles during ACC -> read sequence identical to REQ-034, total latency +4, rd_enable low during stall.
REQ-038 reset_n low at cycle 50 -> all outputs 0 immediately; new start restarts at address 0.
REQ-039 STRIDE=2 (OUT_W=2) -> oij=1 first read address 2; done after 4 pixels (49 cycles from SET).
